// File: rtl/rx_deser_pkg.sv
// Shared types and default parameters for the rx_deserializer block.
//   rx_deser_state_t : word-alignment state (SEARCH, CONFIRM, LOCKED)
//   DEF_*            : default values for WIDTH, ALIGN_PATTERN, LOCK_MATCHES
package rx_deser_pkg;

    localparam int unsigned DEF_WIDTH         = 8;
    localparam logic [7:0]  DEF_ALIGN_PATTERN = 8'h0F;
    localparam int unsigned DEF_LOCK_MATCHES  = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } rx_deser_state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// Serial input shift register and word bit counter.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   din_i          : serial bit sampled this edge
//   cnt_clr_i      : synchronous clear of the bit counter (next bit is bit 0)
//   win_c_o        : word ending with the bit currently on din_i (LSB = oldest)
//   boundary_c_o   : high when din_i carries the last bit of a word
module deser_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             din_i,
    input  logic             cnt_clr_i,
    output logic [WIDTH-1:0] win_c_o,
    output logic             boundary_c_o
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Only the newest WIDTH-1 bits are stored; the oldest bit of the full
    // register is shifted out before anything could read it.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Window, shift and counter next-state
    always_comb begin
        win_c_o      = {din_i, sr_q};
        boundary_c_o = (bit_cnt_q == CNT_LAST);
        sr_d         = win_c_o[WIDTH-1:1];
        if (cnt_clr_i || boundary_c_o) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// Receive-side serial-to-parallel converter with training-pattern word alignment.
//   clk, rst   : sample clock, asynchronous active-high reset
//   din        : serial data, LSB of each word first
//   realign    : one-cycle request to drop lock and restart boundary search
//   dout       : last assembled word (holds between strobes)
//   dout_valid : one-cycle strobe for a new word on dout
//   locked     : word boundary established
// Build option RX_DESERIALIZER_ALIGN_EN: when defined, boundaries are found by
// SEARCH/CONFIRM/LOCKED pattern alignment; when undefined, the boundary is
// fixed at reset release and realign/ALIGN_PATTERN/LOCK_MATCHES are unused.
module rx_deserializer
    import rx_deser_pkg::*;
#(
    parameter int unsigned       WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  ALIGN_PATTERN = WIDTH'(DEF_ALIGN_PATTERN),
    parameter int unsigned       LOCK_MATCHES  = DEF_LOCK_MATCHES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             realign,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             locked
);

    logic [WIDTH-1:0] win_c;
    logic             boundary_c;
    logic             cnt_clr_c;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             locked_q, locked_d;

    deser_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk_i        (clk),
        .rst_i        (rst),
        .din_i        (din),
        .cnt_clr_i    (cnt_clr_c),
        .win_c_o      (win_c),
        .boundary_c_o (boundary_c)
    );

`ifdef RX_DESERIALIZER_ALIGN_EN
    localparam int unsigned       MATCH_W   = $clog2(LOCK_MATCHES + 1);
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_MATCHES);

    rx_deser_state_t    state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               pat_hit_c;

    assign pat_hit_c = (win_c == ALIGN_PATTERN);

    // Alignment FSM next-state and output next-state
    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        cnt_clr_c    = 1'b0;
        if (realign) begin
            // Overrides any boundary this cycle, so that word is dropped.
            state_d   = SEARCH;
            match_d   = '0;
            cnt_clr_c = 1'b1;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (pat_hit_c) begin
                        // Next sampled bit becomes bit 0 of the following word.
                        cnt_clr_c = 1'b1;
                        match_d   = MATCH_W'(1);
                        if (LOCK_MATCHES == 1) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (boundary_c) begin
                        if (pat_hit_c) begin
                            match_d = match_q + MATCH_W'(1);
                            if (match_d == MATCH_TGT) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            match_d = '0;
                            state_d = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary_c) begin
                        dout_d       = win_c;
                        dout_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    match_d = '0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end
`else
    // Fixed boundary: the bit counter starts at reset release and never clears.
    always_comb begin
        cnt_clr_c    = 1'b0;
        dout_d       = boundary_c ? win_c : dout_q;
        dout_valid_d = boundary_c;
        locked_d     = 1'b1;
    end

    logic unused_c;
    assign unused_c = ^{realign, ALIGN_PATTERN, 32'(LOCK_MATCHES)};
`endif

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Self-checking bench for rx_deserializer (WIDTH=8, pattern 0x0F, 2 matches).
// Expected outputs come from a word-level scan of the driven bit stream.
module tb_rx_deserializer;

    localparam int         W    = 8;
    localparam logic [7:0] PAT  = 8'h0F;
    localparam int         LM   = 2;
    localparam int         MAXN = 1024;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         din     = 1'b0;
    logic         realign = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         locked;

    int n_checks = 0;
    int n_fail   = 0;
    int n_st     = 0;

    logic         st_bit    [MAXN];
    logic         st_rl     [MAXN];
    logic         ob_valid  [MAXN];
    logic         ob_locked [MAXN];
    logic [W-1:0] ob_dout   [MAXN];
    logic         ex_valid  [MAXN];
    logic         ex_locked [MAXN];
    logic [W-1:0] ex_dout   [MAXN];

    rx_deserializer #(
        .WIDTH         (W),
        .ALIGN_PATTERN (PAT),
        .LOCK_MATCHES  (LM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .realign    (realign),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Word whose last bit is stream index c; bits before reset release read as 0.
    function automatic logic [W-1:0] win_at(input int c);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (c - (W - 1) + i >= 0) w[i] = st_bit[c - (W - 1) + i];
        end
        return w;
    endfunction

    task automatic put_bit(input logic b);
        st_bit[n_st] = b;
        st_rl[n_st]  = 1'b0;
        n_st++;
    endtask

    task automatic put_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) put_bit(w[i]);
    endtask

    // Expected per-cycle outputs (value right after each sampling edge).
    task automatic model_run(input int n);
        logic [W-1:0] last;
`ifdef RX_DESERIALIZER_ALIGN_EN
        int c, j, b, e, r, nxt, cnt, lockc;
        bit found, busy;
`endif
        for (int i = 0; i < n; i++) begin
            ex_valid[i]  = 1'b0;
            ex_locked[i] = 1'b0;
        end
`ifdef RX_DESERIALIZER_ALIGN_EN
        c = 0;
        while (c < n) begin
            // find the first pattern window not cancelled by realign
            j = c;
            found = 1'b0;
            while (j < n && !found) begin
                if (!st_rl[j] && win_at(j) == PAT) found = 1'b1;
                else j++;
            end
            if (!found) break;
            cnt = 1; lockc = -1; nxt = n; b = j; busy = 1'b1;
            if (cnt >= LM) begin
                lockc = j;
                busy  = 1'b0;
            end
            // confirm the following whole words
            while (busy) begin
                e = b + W;
                r = -1;
                for (int k = b + 1; k <= e && k < n; k++) begin
                    if (st_rl[k] && r < 0) r = k;
                end
                if (r >= 0) begin
                    nxt = r + 1; busy = 1'b0;
                end else if (e >= n) begin
                    nxt = n; busy = 1'b0;
                end else if (win_at(e) == PAT) begin
                    cnt++;
                    b = e;
                    if (cnt >= LM) begin
                        lockc = e; busy = 1'b0;
                    end
                end else begin
                    nxt = e + 1; busy = 1'b0;
                end
            end
            if (lockc >= 0) begin
                r = n;
                for (int k = n - 1; k > lockc; k--) begin
                    if (st_rl[k]) r = k;
                end
                for (int k = lockc; k < r; k++) begin
                    ex_locked[k] = 1'b1;
                    if (k > lockc && (k - lockc) % W == 0) ex_valid[k] = 1'b1;
                end
                nxt = r + 1;
            end
            c = nxt;
        end
`else
        for (int i = 0; i < n; i++) begin
            ex_locked[i] = 1'b1;
            ex_valid[i]  = (i % W == W - 1);
        end
`endif
        last = '0;
        for (int i = 0; i < n; i++) begin
            if (ex_valid[i]) last = win_at(i);
            ex_dout[i] = last;
        end
    endtask

    // Drive the stored stream from a falling edge; record outputs 1 after each rise.
    task automatic drive_stream(input int n);
        for (int i = 0; i < n; i++) begin
            din     = st_bit[i];
            realign = st_rl[i];
            @(posedge clk);
            #1;
            ob_valid[i]  = dout_valid;
            ob_dout[i]   = dout;
            ob_locked[i] = locked;
            @(negedge clk);
        end
        din     = 1'b0;
        realign = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        din     = 1'b0;
        realign = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        n_st = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din     = 1'($urandom);
            realign = 1'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (dout !== '0 || dout_valid !== 1'b0 || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got dout=%h valid=%b locked=%b, want 00/0/0",
                         i, dout, dout_valid, locked);
            end
            @(negedge clk);
        end
        din     = 1'b0;
        realign = 1'b0;
        rst     = 1'b0;
        n_st    = 0;
    endtask

    task automatic test_random();
        int n;
        do_reset();
        while (n_st < 560) begin
            n = $urandom_range(0, 9);
            if (n < 4) put_word(PAT);
            else if (n < 5) begin
                for (int k = 0; k < int'($urandom_range(1, 7)); k++) put_bit(1'($urandom));
            end else put_word(W'($urandom));
        end
        for (int i = 0; i < n_st; i++) st_rl[i] = ($urandom_range(0, 49) == 0);
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL random cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
        end
    endtask

`ifdef RX_DESERIALIZER_ALIGN_EN
    task automatic test_lock_sequence();
        logic [W-1:0] sv[$];
        int           sc[$];
        do_reset();
        for (int k = 0; k < 3; k++) put_bit(1'($urandom));
        put_word(8'h0F); put_word(8'h0F); put_word(8'h0F); put_word(8'h3C);
        put_bit(1'b0);
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL lock_seq cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
            if (ob_valid[i]) begin
                sv.push_back(ob_dout[i]);
                sc.push_back(i);
            end
        end
        n_checks++;
        if (ob_locked[17] !== 1'b0 || ob_locked[18] !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_seq_rise: got locked[17]=%b locked[18]=%b, want 0 then 1",
                     ob_locked[17], ob_locked[18]);
        end
        n_checks++;
        if (sv.size() != 2 || sv[0] !== 8'h0F || sv[1] !== 8'h3C || sc[0] != 26 || sc[1] != 34) begin
            n_fail++;
            $display("FAIL lock_seq_strobes: got %0d strobes, want 2 (0f@26, 3c@34)", sv.size());
        end
    endtask

    task automatic test_confirm_fail();
        logic [W-1:0] sv[$];
        do_reset();
        put_word(8'h0F); put_word(8'h55); put_word(8'h0F); put_word(8'h0F); put_word(8'hA5);
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL confirm_fail cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
            if (ob_valid[i]) sv.push_back(ob_dout[i]);
        end
        n_checks++;
        if (ob_locked[16] !== 1'b0 || ob_locked[31] !== 1'b1) begin
            n_fail++;
            $display("FAIL confirm_fail_lock: got locked[16]=%b locked[31]=%b, want 0 and 1",
                     ob_locked[16], ob_locked[31]);
        end
        n_checks++;
        if (sv.size() != 1 || sv[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL confirm_fail_strobes: got %0d strobes, want 1 with a5", sv.size());
        end
    endtask

    task automatic test_realign_locked();
        logic [W-1:0] sv[$];
        do_reset();
        put_word(8'h0F); put_word(8'h0F); put_word(W'($urandom));
        st_rl[23] = 1'b1;
        put_word(8'h0F); put_word(8'h0F); put_word(8'h81);
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL realign cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
            if (ob_valid[i]) sv.push_back(ob_dout[i]);
        end
        n_checks++;
        if (ob_locked[22] !== 1'b1 || ob_locked[23] !== 1'b0 || ob_valid[23] !== 1'b0) begin
            n_fail++;
            $display("FAIL realign_drop: got locked22=%b locked23=%b valid23=%b, want 1/0/0",
                     ob_locked[22], ob_locked[23], ob_valid[23]);
        end
        n_checks++;
        if (sv.size() != 1 || sv[0] !== 8'h81 || ob_valid[47] !== 1'b1) begin
            n_fail++;
            $display("FAIL realign_strobes: got %0d strobes, want 1 with 81 at cycle 47", sv.size());
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] sv[$];
        do_reset();
        put_word(8'h0F); put_word(8'h0F); put_word(8'h96); put_word(8'h3C);
        for (int k = 0; k < 3; k++) put_bit(1'($urandom));
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (locked !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got locked=%b dout=%h valid=%b, want 0/00/0",
                     locked, dout, dout_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        n_st = 0;
        put_word(8'h55); put_word(8'hAA); put_word(8'h0F); put_word(8'h0F); put_word(8'hC3);
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL async_post cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
            if (ob_valid[i]) sv.push_back(ob_dout[i]);
        end
        n_checks++;
        if (sv.size() != 1 || sv[0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL async_relock: got %0d strobes, want 1 with c3", sv.size());
        end
    endtask
`else
    task automatic test_fixed_boundary();
        int nv;
        do_reset();
        put_word(8'hA5); put_word(8'h3C);
        for (int i = 0; i < n_st; i++) st_rl[i] = (i % 3 == 1);
        model_run(n_st);
        drive_stream(n_st);
        nv = 0;
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL fixed cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
            if (ob_valid[i]) nv++;
        end
        n_checks++;
        if (nv != 2 || ob_valid[7] !== 1'b1 || ob_dout[7] !== 8'hA5 ||
            ob_valid[15] !== 1'b1 || ob_dout[15] !== 8'h3C || ob_locked[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_words: got %0d strobes d7=%h d15=%h l0=%b, want 2, a5, 3c, 1",
                     nv, ob_dout[7], ob_dout[15], ob_locked[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        put_word(8'hA5);
        for (int k = 0; k < 3; k++) put_bit(1'($urandom));
        model_run(n_st);
        drive_stream(n_st);
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (ob_valid[i] !== ex_valid[i] || ob_dout[i] !== ex_dout[i] || ob_locked[i] !== ex_locked[i]) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                         i, ob_valid[i], ob_dout[i], ob_locked[i], ex_valid[i], ex_dout[i], ex_locked[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (locked !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got locked=%b dout=%h valid=%b, want 0/00/0",
                     locked, dout, dout_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        n_st = 0;
        put_word(8'h3C); put_word(8'h5A);
        model_run(n_st);
        drive_stream(n_st);
        n_checks++;
        if (ob_valid[6] !== 1'b0 || ob_valid[7] !== 1'b1 || ob_dout[7] !== 8'h3C ||
            ob_valid[15] !== 1'b1 || ob_dout[15] !== 8'h5A) begin
            n_fail++;
            $display("FAIL async_rebound: got v6=%b v7=%b d7=%h v15=%b d15=%h, want 0 1 3c 1 5a",
                     ob_valid[6], ob_valid[7], ob_dout[7], ob_valid[15], ob_dout[15]);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef RX_DESERIALIZER_ALIGN_EN
        test_lock_sequence();
        test_confirm_fail();
        test_realign_locked();
        test_async_reset();
`else
        test_fixed_boundary();
        test_async_reset();
`endif
        test_random();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
